// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with a per-register pending-write scoreboard for a simple
//   in-order issue stage. Reads are combinational and bypass the writeback
//   and auxiliary (link) write ports, so a value written this cycle is
//   visible this cycle. Each register keeps a small saturating-by-stall
//   counter of issued-but-not-written-back results; the issue stage stalls
//   on a source hazard or when the destination counter is full.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rd_a_addr/use, rd_b_addr/use  source operand addresses and "consumed" flags
//   rd_a_data, rd_b_data       bypassed read data (combinational)
//   iss_valid, iss_code, iss_dst  instruction presented for issue
//   stall                      issue refused this cycle (combinational)
//   wb_code, wb_addr, wb_data  writeback port (writes only for ALU/LW codes)
//   aux_en, aux_addr, aux_data auxiliary write port (does not touch pend)
module regfile_scoreboard #(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int CODE_SIZE = 6,
    parameter int ALU_CODE  = 1,
    parameter int LW_CODE   = 2,
    parameter int PEND_SIZE = 2,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_SIZE-1:0]  rd_a_addr,
    input  logic [REG_SIZE-1:0]  rd_b_addr,
    input  logic                 rd_a_use,
    input  logic                 rd_b_use,
    output logic [DATA_SIZE-1:0] rd_a_data,
    output logic [DATA_SIZE-1:0] rd_b_data,
    input  logic                 iss_valid,
    input  logic [CODE_SIZE-1:0] iss_code,
    input  logic [REG_SIZE-1:0]  iss_dst,
    output logic                 stall,
    input  logic [CODE_SIZE-1:0] wb_code,
    input  logic [REG_SIZE-1:0]  wb_addr,
    input  logic [DATA_SIZE-1:0] wb_data,
    input  logic                 aux_en,
    input  logic [REG_SIZE-1:0]  aux_addr,
    input  logic [DATA_SIZE-1:0] aux_data
);

    localparam int DEPTH = 1 << REG_SIZE;
    localparam logic [PEND_SIZE-1:0] PEND_ONE  = PEND_SIZE'(1);
    localparam logic [PEND_SIZE-1:0] PEND_FULL = '1;
    localparam logic [CODE_SIZE-1:0] ALU_C     = CODE_SIZE'(ALU_CODE);
    localparam logic [CODE_SIZE-1:0] LW_C      = CODE_SIZE'(LW_CODE);

    logic [DATA_SIZE-1:0] regs [DEPTH];
    logic [PEND_SIZE-1:0] pend [DEPTH];

    logic wb_we;
    logic iss_wr;
    logic haz_a;
    logic haz_b;
    logic accept;

    assign wb_we  = (wb_code == ALU_C) || (wb_code == LW_C);
    assign iss_wr = (iss_code == ALU_C) || (iss_code == LW_C);

    function automatic logic is_zero(input logic [REG_SIZE-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // Bypass order: hardwired zero, then writeback, then aux, then array.
    function automatic logic [DATA_SIZE-1:0] read_port(input logic [REG_SIZE-1:0] addr);
        if (is_zero(addr))                  return '0;
        else if (wb_we && wb_addr == addr)  return wb_data;
        else if (aux_en && aux_addr == addr) return aux_data;
        else                                return regs[addr];
    endfunction

    // The last outstanding write landing this cycle is forwarded by the
    // bypass, so it is not a hazard.
    function automatic logic hazard(input logic [REG_SIZE-1:0] addr, input logic use_op);
        return use_op && (pend[addr] != '0) &&
               !(wb_we && wb_addr == addr && pend[addr] == PEND_ONE);
    endfunction

    assign rd_a_data = read_port(rd_a_addr);
    assign rd_b_data = read_port(rd_b_addr);

    assign haz_a  = hazard(rd_a_addr, rd_a_use);
    assign haz_b  = hazard(rd_b_addr, rd_b_use);
    assign stall  = iss_valid && (haz_a || haz_b || (iss_wr && pend[iss_dst] == PEND_FULL));
    assign accept = iss_valid && !stall;

    // NOTE: the array and counters are reset too, because reset must make
    // every register read as 0 immediately; this keeps regs in flops rather
    // than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make the later wb write win over
            // the aux write to the same address within one edge.
            if (aux_en && !is_zero(aux_addr)) regs[aux_addr] <= aux_data;
            if (wb_we && !is_zero(wb_addr))   regs[wb_addr]  <= wb_data;

            for (int r = 0; r < DEPTH; r++) begin
                logic inc;
                logic hit;
                inc = accept && iss_wr && (iss_dst == REG_SIZE'(r)) && !is_zero(iss_dst);
                hit = wb_we && (wb_addr == REG_SIZE'(r));
                if (inc && !hit)
                    pend[r] <= pend[r] + PEND_ONE;
                else if (hit && !inc && pend[r] != '0)
                    pend[r] <= pend[r] - PEND_ONE;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Directed bench for regfile_scoreboard. Inputs change on the falling edge,
//   outputs are compared 1 ns later, state commits on the following rising edge.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_a_addr, rd_b_addr;
    logic        rd_a_use, rd_b_use;
    logic [31:0] rd_a_data, rd_b_data;
    logic        iss_valid;
    logic [5:0]  iss_code;
    logic [4:0]  iss_dst;
    logic        stall;
    logic [5:0]  wb_code;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        aux_en;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
        .rd_a_use(rd_a_use), .rd_b_use(rd_b_use),
        .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
        .iss_valid(iss_valid), .iss_code(iss_code), .iss_dst(iss_dst),
        .stall(stall),
        .wb_code(wb_code), .wb_addr(wb_addr), .wb_data(wb_data),
        .aux_en(aux_en), .aux_addr(aux_addr), .aux_data(aux_data)
    );

    task automatic idle();
        rd_a_addr = '0; rd_b_addr = '0; rd_a_use = 0; rd_b_use = 0;
        iss_valid = 0; iss_code = '0; iss_dst = '0;
        wb_code = '0; wb_addr = '0; wb_data = '0;
        aux_en = 0; aux_addr = '0; aux_data = '0;
    endtask

    // Pass one rising edge, return on the falling edge with inputs idle.
    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic issue(input logic [4:0] dst);
        iss_valid = 1; iss_code = 6'd1; iss_dst = dst;
    endtask

    task automatic wb(input logic [5:0] code, input logic [4:0] addr, input logic [31:0] data);
        wb_code = code; wb_addr = addr; wb_data = data;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        rd_a_addr = 5'd5; rd_b_addr = 5'd31; rd_a_use = 1; iss_valid = 1; iss_code = 6'd1; iss_dst = 5'd5;
        repeat (2) @(negedge clk);
        #1;
        assert_cnt++; if (rd_a_data !== 32'h0) begin fail_cnt++; $display("FAIL reset_rd_a: got %h expected %h", rd_a_data, 32'h0); end
        assert_cnt++; if (rd_b_data !== 32'h0) begin fail_cnt++; $display("FAIL reset_rd_b: got %h expected %h", rd_b_data, 32'h0); end
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL reset_stall: got %b expected 0", stall); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_bypass();
        wb(6'd1, 5'd5, 32'hDEADBEEF);
        rd_a_addr = 5'd5; rd_b_addr = 5'd5;
        #1;
        assert_cnt++; if (rd_a_data !== 32'hDEADBEEF) begin fail_cnt++; $display("FAIL bypass_a: got %h expected %h", rd_a_data, 32'hDEADBEEF); end
        assert_cnt++; if (rd_b_data !== 32'hDEADBEEF) begin fail_cnt++; $display("FAIL bypass_b: got %h expected %h", rd_b_data, 32'hDEADBEEF); end
        tick();
        rd_a_addr = 5'd5;
        #1;
        assert_cnt++; if (rd_a_data !== 32'hDEADBEEF) begin fail_cnt++; $display("FAIL stored_r5: got %h expected %h", rd_a_data, 32'hDEADBEEF); end
        tick();
    endtask

    task automatic test_write_codes();
        wb(6'd3, 5'd7, 32'h1234); rd_a_addr = 5'd7;
        #1;
        assert_cnt++; if (rd_a_data !== 32'h0) begin fail_cnt++; $display("FAIL sw_no_bypass: got %h expected %h", rd_a_data, 32'h0); end
        tick();
        wb(6'd0, 5'd7, 32'h1234);
        tick();
        rd_a_addr = 5'd7;
        #1;
        assert_cnt++; if (rd_a_data !== 32'h0) begin fail_cnt++; $display("FAIL r7_unwritten: got %h expected %h", rd_a_data, 32'h0); end
        tick();
        wb(6'd1, 5'd9, 32'hAAAA0001);
        aux_en = 1; aux_addr = 5'd9; aux_data = 32'h55550002;
        rd_a_addr = 5'd9;
        #1;
        assert_cnt++; if (rd_a_data !== 32'hAAAA0001) begin fail_cnt++; $display("FAIL wb_over_aux_bypass: got %h expected %h", rd_a_data, 32'hAAAA0001); end
        tick();
        rd_a_addr = 5'd9;
        aux_en = 1; aux_addr = 5'd10; aux_data = 32'h00000077; rd_b_addr = 5'd10;
        #1;
        assert_cnt++; if (rd_a_data !== 32'hAAAA0001) begin fail_cnt++; $display("FAIL wb_over_aux_stored: got %h expected %h", rd_a_data, 32'hAAAA0001); end
        assert_cnt++; if (rd_b_data !== 32'h00000077) begin fail_cnt++; $display("FAIL aux_bypass: got %h expected %h", rd_b_data, 32'h77); end
        tick();
        rd_b_addr = 5'd10;
        #1;
        assert_cnt++; if (rd_b_data !== 32'h00000077) begin fail_cnt++; $display("FAIL aux_stored: got %h expected %h", rd_b_data, 32'h77); end
        tick();
    endtask

    task automatic test_hazard();
        iss_valid = 1; iss_code = 6'd2; iss_dst = 5'd3;
        #1;
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL lw_issue_accept: got %b expected 0", stall); end
        tick();
        iss_valid = 1; rd_a_addr = 5'd3; rd_a_use = 1;
        #1;
        assert_cnt++; if (stall !== 1'b1) begin fail_cnt++; $display("FAIL raw_stall_a: got %b expected 1", stall); end
        rd_a_use = 0;
        #1;
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL unused_src_no_stall: got %b expected 0", stall); end
        rd_a_use = 1; iss_valid = 0;
        #1;
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL no_valid_no_stall: got %b expected 0", stall); end
        iss_valid = 1; wb(6'd2, 5'd3, 32'hCAFE0003);
        #1;
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL last_wb_bypassed: got %b expected 0", stall); end
        assert_cnt++; if (rd_a_data !== 32'hCAFE0003) begin fail_cnt++; $display("FAIL last_wb_data: got %h expected %h", rd_a_data, 32'hCAFE0003); end
        tick();
        iss_valid = 1; rd_a_addr = 5'd3; rd_a_use = 1;
        #1;
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL r3_pend_cleared: got %b expected 0", stall); end
        tick();
        // Port b with two outstanding writes: one writeback is not enough.
        issue(5'd6);
        tick();
        issue(5'd6);
        tick();
        iss_valid = 1; rd_b_addr = 5'd6; rd_b_use = 1; wb(6'd1, 5'd6, 32'h6);
        #1;
        assert_cnt++; if (stall !== 1'b1) begin fail_cnt++; $display("FAIL pend2_wb_still_stall: got %b expected 1", stall); end
        tick();
        iss_valid = 1; rd_b_addr = 5'd6; rd_b_use = 1; wb(6'd1, 5'd6, 32'h66);
        #1;
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL pend1_wb_bypass_b: got %b expected 0", stall); end
        assert_cnt++; if (rd_b_data !== 32'h66) begin fail_cnt++; $display("FAIL pend1_wb_data_b: got %h expected %h", rd_b_data, 32'h66); end
        tick();
    endtask

    task automatic test_pend_full();
        for (int i = 0; i < 3; i++) begin
            issue(5'd4);
            #1;
            assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL fill_r4_%0d: got %b expected 0", i, stall); end
            tick();
        end
        issue(5'd4);
        #1;
        assert_cnt++; if (stall !== 1'b1) begin fail_cnt++; $display("FAIL r4_full_stall: got %b expected 1", stall); end
        tick();
        wb(6'd1, 5'd4, 32'h4);
        tick();
        issue(5'd4); wb(6'd1, 5'd4, 32'h44);
        #1;
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL issue_plus_wb_accept: got %b expected 0", stall); end
        tick();
        issue(5'd4);
        #1;
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL r4_back_to_3: got %b expected 0", stall); end
        tick();
        issue(5'd4);
        #1;
        assert_cnt++; if (stall !== 1'b1) begin fail_cnt++; $display("FAIL r4_full_again: got %b expected 1", stall); end
        tick();
        // Drain three, then one extra writeback that must not underflow.
        for (int i = 0; i < 4; i++) begin
            wb(6'd2, 5'd4, 32'h400 + 32'(i));
            tick();
        end
        issue(5'd4);
        #1;
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL no_underflow: got %b expected 0", stall); end
        tick();
        iss_valid = 1; rd_a_addr = 5'd4; rd_a_use = 1;
        #1;
        assert_cnt++; if (stall !== 1'b1) begin fail_cnt++; $display("FAIL r4_pend1_stall: got %b expected 1", stall); end
        tick();
        wb(6'd1, 5'd4, 32'h4444);
        tick();
    endtask

    task automatic test_zero_reg();
        wb(6'd1, 5'd0, 32'hFFFFFFFF); issue(5'd0);
        aux_en = 1; aux_addr = 5'd0; aux_data = 32'h12345678;
        rd_a_addr = 5'd0; rd_a_use = 1;
        #1;
        assert_cnt++; if (rd_a_data !== 32'h0) begin fail_cnt++; $display("FAIL r0_bypass_zero: got %h expected %h", rd_a_data, 32'h0); end
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL r0_issue_stall: got %b expected 0", stall); end
        tick();
        issue(5'd0); rd_a_addr = 5'd0; rd_a_use = 1; rd_b_addr = 5'd0; rd_b_use = 1;
        #1;
        assert_cnt++; if (rd_a_data !== 32'h0) begin fail_cnt++; $display("FAIL r0_stored_zero: got %h expected %h", rd_a_data, 32'h0); end
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL r0_never_pending: got %b expected 0", stall); end
        tick();
    endtask

    task automatic test_async_reset();
        wb(6'd1, 5'd12, 32'h12121212); issue(5'd13);
        tick();
        iss_valid = 1; rd_a_addr = 5'd12; rd_b_addr = 5'd13; rd_b_use = 1;
        #1;
        assert_cnt++; if (rd_a_data !== 32'h12121212) begin fail_cnt++; $display("FAIL pre_reset_r12: got %h expected %h", rd_a_data, 32'h12121212); end
        assert_cnt++; if (stall !== 1'b1) begin fail_cnt++; $display("FAIL pre_reset_r13_stall: got %b expected 1", stall); end
        #1 rst_n = 0;
        #1;
        assert_cnt++; if (rd_a_data !== 32'h0) begin fail_cnt++; $display("FAIL async_reset_r12: got %h expected %h", rd_a_data, 32'h0); end
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL async_reset_stall: got %b expected 0", stall); end
        rd_a_addr = 5'd5;
        #1;
        assert_cnt++; if (rd_a_data !== 32'h0) begin fail_cnt++; $display("FAIL async_reset_r5: got %h expected %h", rd_a_data, 32'h0); end
        @(negedge clk);
        rst_n = 1;
        idle();
        iss_valid = 1; rd_a_addr = 5'd12; rd_b_addr = 5'd13; rd_b_use = 1;
        #1;
        assert_cnt++; if (rd_a_data !== 32'h0) begin fail_cnt++; $display("FAIL post_reset_r12: got %h expected %h", rd_a_data, 32'h0); end
        assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("FAIL post_reset_r13: got %b expected 0", stall); end
        tick();
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_bypass();
        test_write_codes();
        test_hazard();
        test_pend_full();
        test_zero_reg();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
